// File: rtl/map_pkg.sv
// Shared constants, types and helpers for the map RAM access arbiter.
package map_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned COORD_W      = 5;
  localparam int unsigned SPRITE_W     = 3;
  localparam int unsigned LOCK_TIMEOUT = 16;

  localparam logic [SPRITE_W-1:0] BLACK   = 3'b000;
  localparam logic [SPRITE_W-1:0] BIG_DOT = 3'b001;
  localparam logic [SPRITE_W-1:0] WALL    = 3'b011;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // One map RAM access as presented on the memory side.
  typedef struct packed {
    logic                we;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [SPRITE_W-1:0] wdata;
  } map_access_t;

  // Width of an index into n items, never zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating first-one search: lowest set request at or above ptr, wrapping around.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] rotated;
  logic [PTR_W-1:0]     offset;
  logic [PTR_W:0]       idx_sum;

  // Bit k of the low half is request (ptr + k) mod NUM_REQ.
  assign rotated = {req, req} >> ptr;

  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid  = 1'b1;
        offset = PTR_W'(i);
      end
    end
  end

  always_comb begin
    idx_sum    = {1'b0, ptr} + {1'b0, offset};
    winner_idx = idx_sum[PTR_W-1:0];
    if (idx_sum >= (PTR_W + 1)'(NUM_REQ)) begin
      winner_idx = PTR_W'(idx_sum - (PTR_W + 1)'(NUM_REQ));
    end
  end

  always_comb begin
    winner = '0;
    if (valid) begin
      winner[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/map_access_arbiter.sv
// Arbitrates Pacman and ghost requesters onto a single synchronous map RAM port,
// with read-modify-write locking bounded by a timeout.
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int unsigned NUM_REQ      = map_pkg::NUM_REQ,
  parameter int unsigned LOCK_TIMEOUT = map_pkg::LOCK_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [COORD_W*NUM_REQ-1:0]  req_x,
  input  logic [COORD_W*NUM_REQ-1:0]  req_y,
  input  logic [SPRITE_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [SPRITE_W-1:0]         rdata,
  output logic                        lock_err,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [COORD_W-1:0]          mem_x,
  output logic [COORD_W-1:0]          mem_y,
  output logic [SPRITE_W-1:0]         mem_wdata,
  input  logic [SPRITE_W-1:0]         mem_rdata
);

  localparam int unsigned PtrW   = idx_width(NUM_REQ);
  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     owner_q, owner_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                lock_err_q, lock_err_d;
  logic                mem_en_q, mem_en_d;
  map_access_t         mem_q, mem_d;
  logic [NUM_REQ-1:0]  rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [PtrW-1:0]     pick_idx;
  logic                pick_valid;
  logic [PtrW-1:0]     gnt_idx;
  logic                gnt_any;
  logic                gnt_lock;
  map_access_t         acc_sel;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] idx);
    if (idx == PtrW'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + PtrW'(1);
  endfunction

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_picker (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // While locked only the owner can win; everyone else simply keeps waiting.
  always_comb begin
    gnt     = '0;
    gnt_idx = owner_q;
    if (state_q == StIdle) begin
      gnt_idx = pick_idx;
      if (pick_valid) begin
        gnt = pick_onehot;
      end
    end else if (req[owner_q]) begin
      gnt[owner_q] = 1'b1;
    end
    if (!resetn) begin
      gnt = '0;
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_lock = req_lock[gnt_idx];

  always_comb begin
    acc_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PtrW'(i) == gnt_idx) begin
        acc_sel.we    = req_we[i];
        acc_sel.x     = req_x[i*COORD_W +: COORD_W];
        acc_sel.y     = req_y[i*COORD_W +: COORD_W];
        acc_sel.wdata = req_wdata[i*SPRITE_W +: SPRITE_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    lock_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          if (gnt_lock) begin
            state_d = StLocked;
            owner_d = gnt_idx;
            timer_d = '0;
          end else begin
            ptr_d = ptr_inc(gnt_idx);
          end
        end
      end
      StLocked: begin
        timer_d = timer_q + TimerW'(1);
        if (gnt_any && !gnt_lock) begin
          state_d = StIdle;
          ptr_d   = ptr_inc(owner_q);
          timer_d = '0;
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          // Last permitted locked cycle: take the lock back even if re-locked now.
          state_d    = StIdle;
          ptr_d      = ptr_inc(owner_q);
          timer_d    = '0;
          lock_err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mem_en_d = gnt_any;
    mem_d    = mem_q;
    if (gnt_any) begin
      mem_d = acc_sel;
    end else begin
      mem_d.we = 1'b0;
    end
    rd_pend_d = (gnt_any && !acc_sel.we) ? gnt : '0;
    rvalid_d  = rd_pend_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      timer_q    <= '0;
      lock_err_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_q      <= '{we: 1'b0, x: '0, y: '0, wdata: BLACK};
      rd_pend_q  <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      lock_err_q <= lock_err_d;
      mem_en_q   <= mem_en_d;
      mem_q      <= mem_d;
      rd_pend_q  <= rd_pend_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_q.we;
  assign mem_x     = mem_q.x;
  assign mem_y     = mem_q.y;
  assign mem_wdata = mem_q.wdata;
  assign lock_err  = lock_err_q;
  assign rvalid    = rvalid_q;
  // RAM read data lands in the same cycle rvalid is raised.
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Randomized and directed bench for map_access_arbiter against a behavioural model.
module tb_map_access_arbiter;
  import map_pkg::*;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    int         who;
    logic [2:0] d;
  } rd_t;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0, req_we = '0, req_lock = '0;
  logic [5*N-1:0] req_x = '0, req_y = '0;
  logic [3*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, rvalid;
  logic [2:0]     rdata, mem_wdata, mem_rdata;
  logic           lock_err, mem_en, mem_we;
  logic [4:0]     mem_x, mem_y;

  map_access_arbiter dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .lock_err  (lock_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_x     (mem_x),
    .mem_y     (mem_y),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] init_val(input int a);
    case (a % 3)
      0:       return BLACK;
      1:       return BIG_DOT;
      default: return WALL;
    endcase
  endfunction

  // Synchronous map RAM.
  logic [2:0] ram    [0:1023];
  bit         ram_wr [0:1023];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[{mem_x, mem_y}]    <= mem_wdata;
        ram_wr[{mem_x, mem_y}] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[{mem_x, mem_y}] ? ram[{mem_x, mem_y}] : init_val(int'({mem_x, mem_y}));
      end
    end
  end

  // Behavioural model state.
  bit         m_locked;
  int         m_owner, m_ptr, m_timer, m_last_w;
  logic [2:0] m_map [int];
  bit         p_wr;
  int         p_addr;
  logic [2:0] p_data;
  bit         e_en, e_we, e_lerr;
  logic [4:0] e_x, e_y;
  logic [2:0] e_wd;
  rd_t        rdq [$];

  int         cyc, checks, errors;
  logic [N-1:0] s_gnt, s_rv;
  logic       s_lerr, s_en, s_we;
  logic [4:0] s_x, s_y;
  logic [2:0] s_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] map_rd(input int a);
    if (m_map.exists(a)) return m_map[a];
    return init_val(a);
  endfunction

  function automatic int model_pick();
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic step();
    int         w, a;
    logic [N-1:0] eg, erv;
    logic [2:0] erd;
    rd_t        r;
    @(negedge clock);
    if (!resetn) begin
      m_locked = 0; m_ptr = 0; m_timer = 0;
      e_en = 0; e_we = 0; e_lerr = 0;
      rdq.delete();
    end else if (p_wr) begin
      m_map[p_addr] = p_data;
    end
    p_wr = 0;
    w  = resetn ? model_pick() : -1;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    erv = '0;
    erd = '0;
    if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
      erv[rdq[0].who] = 1'b1;
      erd = rdq[0].d;
      void'(rdq.pop_front());
    end
    chk("gnt", gnt, eg);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) begin
      chk("mem_x", mem_x, e_x);
      chk("mem_y", mem_y, e_y);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    end
    chk("rvalid", rvalid, erv);
    if (erv != 0) chk("rdata", rdata, erd);
    chk("lock_err", lock_err, e_lerr);
    s_gnt = gnt; s_rv = rvalid; s_lerr = lock_err;
    s_en = mem_en; s_we = mem_we; s_x = mem_x; s_y = mem_y; s_wd = mem_wdata;

    e_lerr = 0;
    if (w >= 0) begin
      e_en = 1; e_we = req_we[w];
      e_x = req_x[w*5 +: 5]; e_y = req_y[w*5 +: 5]; e_wd = req_wdata[w*3 +: 3];
      a = int'({e_x, e_y});
      if (e_we) begin
        p_wr = 1; p_addr = a; p_data = e_wd;
      end else begin
        r.cyc = cyc + 2; r.who = w; r.d = map_rd(a);
        rdq.push_back(r);
      end
    end else begin
      e_en = 0; e_we = 0;
    end
    if (resetn) begin
      if (!m_locked) begin
        if (w >= 0) begin
          if (req_lock[w]) begin
            m_locked = 1; m_owner = w; m_timer = 0;
          end else begin
            m_ptr = (w + 1) % N;
          end
        end
      end else begin
        m_timer++;
        if (w >= 0 && !req_lock[w]) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N;
        end else if (m_timer == LOCK_TIMEOUT) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; e_lerr = 1;
        end
      end
    end
    m_last_w = w;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input bit we, input bit lk, input int x, input int y,
                         input int wd);
    req[i] = 1'b1; req_we[i] = we; req_lock[i] = lk;
    req_x[i*5 +: 5] = 5'(x); req_y[i*5 +: 5] = 5'(y); req_wdata[i*3 +: 3] = 3'(wd);
  endtask

  task automatic do_reset();
    req = '0;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    int pulses;
    logic [N-1:0] rv_seen;
    checks = 0; errors = 0; cyc = 0; m_last_w = -1;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_timer = 0;
    e_en = 0; e_we = 0; e_lerr = 0; p_wr = 0;

    do_reset();

    // Two readers from ptr 0.
    set_req(1, 0, 0, 1, 2, 0);
    set_req(2, 0, 0, 2, 3, 0);
    step(); chk("d1_gnt_a", s_gnt, 4'b0010);
    req[1] = 0;
    step(); chk("d1_gnt_b", s_gnt, 4'b0100);
    req[2] = 0;
    step(); chk("d1_rv_a", s_rv, 4'b0010);
    step(); chk("d1_rv_b", s_rv, 4'b0100);

    // Locked read-modify-write blocks requester 2.
    do_reset();
    set_req(0, 0, 1, 3, 7, 0);
    set_req(2, 0, 0, 1, 1, 0);
    step(); chk("d2_gnt_rd", s_gnt, 4'b0001);
    req[0] = 0;
    step(); chk("d2_blocked", s_gnt, 4'b0000);
    chk("d2_mem_rd", {s_en, s_we, s_x, s_y}, {1'b1, 1'b0, 5'd3, 5'd7});
    set_req(0, 1, 0, 3, 7, 0);
    step(); chk("d2_gnt_wr", s_gnt, 4'b0001);
    req[0] = 0;
    step(); chk("d2_gnt_after", s_gnt, 4'b0100);
    chk("d2_mem_wr", {s_en, s_we, s_x, s_y, s_wd}, {1'b1, 1'b1, 5'd3, 5'd7, 3'b000});
    req[2] = 0;
    step(); step();

    // Lock held past the timeout.
    do_reset();
    set_req(1, 0, 1, 2, 2, 0);
    step(); chk("d3_lock_gnt", s_gnt, 4'b0010);
    req[1] = 0;
    set_req(2, 0, 0, 4, 4, 0);
    set_req(3, 0, 0, 5, 5, 0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      pulses += int'(s_lerr);
      chk("d3_held_gnt", s_gnt, 4'b0000);
    end
    chk("d3_no_early_err", pulses, 0);
    step(); chk("d3_lock_err", s_lerr, 1'b1);
    chk("d3_next_gnt", s_gnt, 4'b0100);
    req[2] = 0;
    step(); chk("d3_err_once", s_lerr, 1'b0);
    req[3] = 0;
    step(); step();

    // Everyone requesting continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, i, i + 8, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("d4_order", s_gnt, 4'b0001 << (k % 4));
    end
    req = '0;
    step(); step(); step();

    // Reset right after a read grant.
    do_reset();
    set_req(0, 0, 0, 5, 5, 0);
    step(); chk("d5_gnt", s_gnt, 4'b0001);
    req[0] = 0;
    resetn = 1'b0;
    step(); chk("d5_mem_en", s_en, 1'b0);
    rv_seen = s_rv;
    resetn = 1'b1;
    step(); rv_seen |= s_rv;
    step(); rv_seen |= s_rv;
    chk("d5_no_rvalid", rv_seen, 4'b0000);
    set_req(0, 0, 0, 6, 6, 0);
    set_req(3, 0, 0, 7, 7, 0);
    step(); chk("d5_ptr0", s_gnt, 4'b0001);
    req = '0;
    step(); step(); step();

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(499) == 0) resetn = 1'b0;
      if (m_last_w >= 0) req[m_last_w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            set_req(i, 1'($urandom_range(1)), $urandom_range(3) == 0, int'($urandom_range(3)),
                    int'($urandom_range(3)), int'($urandom_range(7)));
          end
        end else if ($urandom_range(31) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end
    req = '0;
    resetn = 1'b1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_access_arbiter.md
MAP_ACCESS_ARBITER -- requirements
Module: map_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (Pacman collision path = 0, ghosts = 1..3).
REQ-002 Parameter LOCK_TIMEOUT, 16, max cycles a requester may hold a lock.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 req  in  NUM_REQ  per-requester access request, held until granted.
REQ-006 req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-007 req_lock  in  NUM_REQ  1 = keep ownership after this access (read-modify-write).
REQ-008 req_x, req_y  in  5*NUM_REQ each  packed map tile coordinates, slice i = requester i.
REQ-009 req_wdata  in  3*NUM_REQ  packed sprite code to write.
REQ-010 gnt  out  NUM_REQ  one-hot, combinational; access accepted this cycle.
REQ-011 rvalid  out  NUM_REQ  one-hot pulse; rdata valid for that requester.
REQ-012 rdata  out  3  read sprite code, shared by all requesters.
REQ-013 lock_err  out  1  one-cycle pulse on forced lock release.
REQ-014 mem_en, mem_we  out  1 each  map RAM enable and write strobe, registered.
REQ-015 mem_x, mem_y  out  5 each  map RAM address, registered.
REQ-016 mem_wdata  out  3  map RAM write data, registered.
REQ-017 mem_rdata  in  3  map RAM synchronous read data, one cycle after mem_en.

Function
REQ-018 At most one gnt bit SHALL be high per cycle; gnt[i] only when req[i]=1.
REQ-019 FSM states SHALL be IDLE (no owner) and LOCKED (owner registered).
REQ-020 In IDLE, the winner SHALL be the first requester with req=1 searching upward, with wrap, from index ptr.
REQ-021 ptr SHALL become (winner+1) mod NUM_REQ on every grant made in IDLE with req_lock=0.
REQ-022 A grant with req_lock=1 in IDLE SHALL move to LOCKED, owner=winner, and clear the lock timer.
REQ-023 In LOCKED only the owner SHALL be grantable; other requests wait, no starvation of owner.
REQ-024 An owner grant with req_lock=0 SHALL return to IDLE with ptr=owner+1 mod NUM_REQ.
REQ-025 Same-cycle release and another pending req: release takes effect at the edge; the other is granted no earlier than the next cycle.
REQ-026 Lock timer SHALL count cycles in LOCKED; on reaching LOCKED_TIMEOUT it SHALL force IDLE, pulse lock_err, and set ptr=owner+1.
REQ-027 On a grant in cycle N, mem_en=1 and mem_we/mem_x/mem_y/mem_wdata SHALL reflect the granted slices in cycle N+1; otherwise mem_en=0, mem_we=0.
REQ-028 For a read granted in cycle N, rvalid[winner] SHALL pulse in cycle N+2 with rdata=mem_rdata.
REQ-029 Writes SHALL produce no rvalid.
REQ-030 Back-to-back grants on consecutive cycles SHALL be supported; throughput one access per cycle.
REQ-031 A requester deasserting req before its grant SHALL lose its turn with no side effects.

Reset
REQ-032 Asserting resetn low SHALL immediately force: state IDLE, ptr=0, timer=0, mem_en=0, mem_we=0, mem_x=mem_y=0, mem_wdata=0, rvalid=0, lock_err=0.
REQ-033 Reads in flight when reset asserts SHALL be dropped; no rvalid after deassertion.
REQ-034 gnt SHALL be 0 while resetn=0.

Structure
REQ-035 Package map_pkg SHALL hold NUM_REQ, COORD_W=5, SPRITE_W=3, LOCK_TIMEOUT, and sprite codes BLACK=3'b000, BIG_DOT=3'b001, WALL=3'b011.
REQ-036 The rotating first-one search SHALL be a sub-module rr_priority_picker (inputs req, ptr; output one-hot winner).

Verification
REQ-037 req=4'b0110, ptr=0, all reads -> gnt=0010 then 0100; rvalid[1] and rvalid[2] two cycles after each grant.
REQ-038 Requester 0 read with lock=1 at (3,7), then write lock=0 wdata=000 while req[2]=1 -> req 2 blocked until write granted; mem sees read (3,7) then write (3,7,000).
REQ-039 Owner holds lock 16 cycles -> lock_err pulses once, state IDLE, next grant goes to index owner+1 if requesting.
REQ-040 All four requesting continuously -> grant order 0,1,2,3,0 with no gaps.
REQ-041 resetn low one cycle after a read grant -> no rvalid, mem_en=0, ptr=0 after release.
